// File: rtl/grid_spi_if.sv
// grid_spi_if: SPI (mode 0) slave front-end for the analog grid.
// The command/data frames set the grid operands and start conversions.
// A settle counter times each conversion before the grid result is
// captured. Every SPI input is resynchronised into the clk domain.
module grid_spi_if #(
  parameter int unsigned SETTLE_CYCLES = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] din,
  output logic       sign,
  output logic [7:0] win,
  output logic [7:0] bias,
  output logic       trig,
  input  logic [7:0] dout
);

  localparam logic [15:0] CNT_LOAD = 16'(SETTLE_CYCLES - 1);

  localparam logic [7:0] CMD_DIN  = 8'h01;
  localparam logic [7:0] CMD_WIN  = 8'h02;
  localparam logic [7:0] CMD_BIAS = 8'h03;
  localparam logic [7:0] CMD_SIGN = 8'h04;
  localparam logic [7:0] CMD_TRIG = 8'h05;
  localparam logic [7:0] CMD_RES  = 8'h06;
  localparam logic [7:0] CMD_STAT = 8'h07;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_HOLD} spi_st_e;
  typedef enum logic       {C_READY, C_BUSY} cmp_st_e;

  // ---------------------------------------------------------------------
  // Input synchronisers. Bits [1:0] form the 2-flop synchroniser and bit
  // [2] is the history used for edge detection. The cs_n chain resets
  // low so that a cs_n held low across reset is not seen as a new
  // falling edge. A transfer then needs cs_n to go high and come back low.
  // ---------------------------------------------------------------------
  logic [2:0] sclk_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;

  // Shift the raw SPI pins into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      csn_q  <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      csn_q  <= {csn_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_hi, mosi_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = csn_q[2] & ~csn_q[1];
  assign cs_hi     = csn_q[1];
  assign mosi_s    = mosi_q[1];

  // ---------------------------------------------------------------------
  // SPI frame engine
  // ---------------------------------------------------------------------
  spi_st_e     spi_st_q;
  logic [3:0]  bit_cnt_q;
  logic [6:0]  sh_q;
  logic [7:0]  cmd_q;
  logic [7:0]  data_q;
  logic [7:0]  rd_sh_q;
  logic        miso_q;
  logic        frame_done_q;

  // Compute-side state is referenced by the read mux below
  cmp_st_e     cmp_st_q;
  logic [15:0] cnt_q;
  logic [7:0]  result_q;
  logic        valid_q;
  logic        busy;
  assign busy = (cmp_st_q == C_BUSY);

  logic [7:0] byte_next;
  logic [7:0] rd_byte;
  assign byte_next = {sh_q, mosi_s};

  // Read byte chosen from the command byte as it completes
  always_comb begin
    rd_byte = '0;
    case (byte_next)
      CMD_RES:  rd_byte = result_q;
      CMD_STAT: rd_byte = {6'b0, busy, valid_q};
      default:  rd_byte = '0;
    endcase
  end

  // Frame sequencing: shift in on sclk rise, shift read data out on sclk fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_st_q     <= S_IDLE;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      rd_sh_q      <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cs_hi) begin
        spi_st_q  <= S_IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        case (spi_st_q)
          S_IDLE: begin
            if (cs_fall) begin
              spi_st_q  <= S_CMD;
              bit_cnt_q <= '0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              sh_q      <= byte_next[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                cmd_q    <= byte_next;
                rd_sh_q  <= rd_byte;
                spi_st_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (sclk_fall) begin
              miso_q  <= rd_sh_q[7];
              rd_sh_q <= {rd_sh_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              sh_q      <= byte_next[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                data_q       <= byte_next;
                frame_done_q <= 1'b1;
                spi_st_q     <= S_HOLD;
              end
            end
          end
          S_HOLD: miso_q <= 1'b0;
          default: spi_st_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Grid registers and conversion sequencer
  // ---------------------------------------------------------------------
  logic [7:0] din_q, win_q, bias_q;
  logic       sign_q, trig_q;

  // Apply completed frames and time the conversion. A capture is written
  // after the result-read clear, so a capture in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_st_q <= C_READY;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      din_q    <= '0;
      win_q    <= '0;
      bias_q   <= '0;
      sign_q   <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (frame_done_q && cmd_q == CMD_RES) valid_q <= 1'b0;
      case (cmp_st_q)
        C_READY: begin
          if (frame_done_q) begin
            case (cmd_q)
              CMD_DIN:  din_q  <= data_q;
              CMD_WIN:  win_q  <= data_q;
              CMD_BIAS: bias_q <= data_q;
              CMD_SIGN: sign_q <= data_q[0];
              CMD_TRIG: begin
                trig_q   <= 1'b1;
                valid_q  <= 1'b0;
                cnt_q    <= CNT_LOAD;
                cmp_st_q <= C_BUSY;
              end
              default: ;
            endcase
          end
        end
        C_BUSY: begin
          if (cnt_q == '0) begin
            result_q <= dout;
            valid_q  <= 1'b1;
            cmp_st_q <= C_READY;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: cmp_st_q <= C_READY;
      endcase
    end
  end

  assign miso = miso_q;
  assign din  = din_q;
  assign win  = win_q;
  assign bias = bias_q;
  assign sign = sign_q;
  assign trig = trig_q;

endmodule
